// File: rtl/mcctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// funct fields, ALU operation codes and the instruction class enum.
package mcctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXECUTE = 4'd2,
        ST_MEM     = 4'd3,
        ST_WB      = 4'd4,
        ST_TRAP    = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_ADDI   = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BEQ    = 3'd5,
        CLS_BNE    = 3'd6
    } cls_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    function automatic logic cls_uses_imm(input cls_e c);
        return (c == CLS_ADDI) || (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

    function automatic logic cls_is_branch(input cls_e c);
        return (c == CLS_BEQ) || (c == CLS_BNE);
    endfunction

endpackage

// File: rtl/mcctrl_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 to instruction class,
// ALU operation code and a legal flag. Anything not explicitly listed is illegal.
module mcctrl_decoder
    import mcctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output cls_e       o_cls,
    output logic [3:0] o_alu,
    output logic       o_legal
);

    logic w_f7_base;
    logic w_f7_alt;

    assign w_f7_base = (i_funct7 == F7_BASE);
    assign w_f7_alt  = (i_funct7 == F7_ALT);

    always_comb begin
        o_cls   = CLS_NONE;
        o_alu   = ALU_AND;
        o_legal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct3)
                    F3_ADD_SUB: begin
                        if (w_f7_base) begin
                            o_cls = CLS_RTYPE; o_alu = ALU_ADD; o_legal = 1'b1;
                        end else if (w_f7_alt) begin
                            o_cls = CLS_RTYPE; o_alu = ALU_SUB; o_legal = 1'b1;
                        end
                    end
                    F3_XOR: if (w_f7_base) begin
                        o_cls = CLS_RTYPE; o_alu = ALU_XOR; o_legal = 1'b1;
                    end
                    F3_SRL: if (w_f7_base) begin
                        o_cls = CLS_RTYPE; o_alu = ALU_SRL; o_legal = 1'b1;
                    end
                    F3_OR: if (w_f7_base) begin
                        o_cls = CLS_RTYPE; o_alu = ALU_OR; o_legal = 1'b1;
                    end
                    F3_AND: if (w_f7_base) begin
                        o_cls = CLS_RTYPE; o_alu = ALU_AND; o_legal = 1'b1;
                    end
                    default: ;
                endcase
            end
            // funct7 of the I/S/B formats is immediate data, so it is not checked
            OP_ADDI: if (i_funct3 == F3_ADD_SUB) begin
                o_cls = CLS_ADDI; o_alu = ALU_ADDI; o_legal = 1'b1;
            end
            OP_LOAD: if (i_funct3 == F3_WORD) begin
                o_cls = CLS_LOAD; o_alu = ALU_ADD; o_legal = 1'b1;
            end
            OP_STORE: if (i_funct3 == F3_WORD) begin
                o_cls = CLS_STORE; o_alu = ALU_ADD; o_legal = 1'b1;
            end
            OP_BRANCH: begin
                if (i_funct3 == F3_BEQ) begin
                    o_cls = CLS_BEQ; o_alu = ALU_SUB; o_legal = 1'b1;
                end else if (i_funct3 == F3_BNE) begin
                    o_cls = CLS_BNE; o_alu = ALU_BNE; o_legal = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Self-sequencing multicycle control FSM with dmem handshake, beq/bne resolution,
// illegal trap and retired-instruction counter. MCCTRL_MEM_TIMEOUT_EN adds a MEM wait timeout.
//
// state   | meaning
// FETCH   | load IR, PC <= PC+4
// DECODE  | latch class and ALU code, trap if illegal
// EXECUTE | ALU operation, branch resolution
// MEM     | data memory access, wait for dmem_ready
// WB      | register file write
// TRAP    | illegal instruction (or MEM timeout), sticky until reset
module multicycle_control
    import mcctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic             i_zero,
    input  logic             i_dmem_ready,
    output logic             o_irwrite,
    output logic             o_pc_write,
    output logic             o_pc_src,
    output logic [3:0]       o_alucontrol,
    output logic             o_alusrc,
    output logic             o_memread,
    output logic             o_memwrite,
    output logic             o_memtoreg,
    output logic             o_regwrite,
    output logic             o_branch,
    output logic             o_illegal,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_instret
);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("multicycle_control: MEM_TIMEOUT and CNT_W must be at least 1");
    end

    cls_e       w_dec_cls;
    logic [3:0] w_dec_alu;
    logic       w_dec_legal;
    logic       w_br_taken;
    logic       w_mem_timeout;

    state_e           r_state;
    cls_e             r_cls;
    logic [3:0]       r_alu;
    logic [CNT_W-1:0] r_instret;
    logic             r_irwrite;
    logic             r_pc_write;
    logic             r_alusrc;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic             r_regwrite;
    logic             r_branch;
    logic             r_illegal;

    mcctrl_decoder u_decoder (
        .i_opcode (i_opcode),
        .i_funct3 (i_funct3),
        .i_funct7 (i_funct7),
        .o_cls    (w_dec_cls),
        .o_alu    (w_dec_alu),
        .o_legal  (w_dec_legal)
    );

    // r_branch is only ever set for the EXECUTE cycle of beq/bne
    assign w_br_taken = r_branch & ((r_cls == CLS_BNE) ? ~i_zero : i_zero);

`ifdef MCCTRL_MEM_TIMEOUT_EN
    localparam int              TO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] r_mem_tmr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_tmr <= TO_LAST;
        end else if (r_state != ST_MEM) begin
            r_mem_tmr <= TO_LAST;
        end else if (r_mem_tmr != '0) begin
            r_mem_tmr <= r_mem_tmr - TO_W'(1);
        end
    end

    assign w_mem_timeout = (r_state == ST_MEM) && (r_mem_tmr == '0);
`else
    assign w_mem_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_FETCH;
            r_cls      <= CLS_NONE;
            r_alu      <= '0;
            r_instret  <= '0;
            r_irwrite  <= 1'b1;
            r_pc_write <= 1'b1;
            r_alusrc   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_irwrite  <= 1'b0;
            r_pc_write <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_cls <= w_dec_cls;
                    r_alu <= w_dec_alu;
                    if (!w_dec_legal) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state  <= ST_EXECUTE;
                        r_alusrc <= cls_uses_imm(w_dec_cls);
                        r_branch <= cls_is_branch(w_dec_cls);
                    end
                end
                ST_EXECUTE: begin
                    case (r_cls)
                        CLS_BEQ, CLS_BNE: begin
                            r_state    <= ST_FETCH;
                            r_instret  <= r_instret + CNT_W'(1);
                            r_irwrite  <= 1'b1;
                            r_pc_write <= 1'b1;
                        end
                        CLS_RTYPE, CLS_ADDI: begin
                            r_state    <= ST_WB;
                            r_regwrite <= 1'b1;
                        end
                        CLS_LOAD: begin
                            r_state   <= ST_MEM;
                            r_memread <= 1'b1;
                        end
                        CLS_STORE: begin
                            r_state    <= ST_MEM;
                            r_memwrite <= 1'b1;
                        end
                        default: begin
                            r_state   <= ST_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (i_dmem_ready) begin
                        if (r_cls == CLS_LOAD) begin
                            r_state    <= ST_WB;
                            r_regwrite <= 1'b1;
                            r_memtoreg <= 1'b1;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_instret  <= r_instret + CNT_W'(1);
                            r_irwrite  <= 1'b1;
                            r_pc_write <= 1'b1;
                        end
                    end else if (w_mem_timeout) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_memread  <= (r_cls == CLS_LOAD);
                        r_memwrite <= (r_cls == CLS_STORE);
                    end
                end
                ST_WB: begin
                    r_state    <= ST_FETCH;
                    r_instret  <= r_instret + CNT_W'(1);
                    r_irwrite  <= 1'b1;
                    r_pc_write <= 1'b1;
                end
                ST_TRAP: begin
                    r_illegal <= 1'b1;
                end
                default: begin
                    r_state    <= ST_FETCH;
                    r_irwrite  <= 1'b1;
                    r_pc_write <= 1'b1;
                end
            endcase
        end
    end

    assign o_irwrite    = r_irwrite;
    assign o_pc_write   = r_pc_write | w_br_taken;
    assign o_pc_src     = w_br_taken;
    assign o_alucontrol = (r_state == ST_EXECUTE) ? r_alu : 4'b0000;
    assign o_alusrc     = r_alusrc;
    assign o_memread    = r_memread;
    assign o_memwrite   = r_memwrite;
    assign o_memtoreg   = r_memtoreg;
    assign o_regwrite   = r_regwrite;
    assign o_branch     = r_branch;
    assign o_illegal    = r_illegal;
    assign o_state      = r_state;
    assign o_instret    = r_instret;

endmodule
